// File: rtl/divider_pipe.sv
// Fully pipelined restoring integer divider (DIV/DIVU/REM/REMU), one operation per cycle.
// Pre-stage takes magnitudes, XLEN/BPS iteration stages resolve BPS quotient bits each, post-stage restores signs.
module divider_pipe #(
    parameter int XLEN  = 32,
    parameter int BPS   = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_dividend,
    input  logic [XLEN-1:0]  in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int N = XLEN / BPS;
    localparam int S = N + 2;

    logic [S-1:0] vld_q, vld_d;

    // Index 0 is the pre-stage, 1..N are the iteration stages.
    logic [XLEN-1:0]  rem_q  [0:N];
    logic [XLEN-1:0]  rem_d  [0:N];
    logic [XLEN-1:0]  dq_q   [0:N];
    logic [XLEN-1:0]  dq_d   [0:N];
    logic [XLEN-1:0]  dvs_q  [0:N-1];
    logic [XLEN-1:0]  dvs_d  [0:N-1];
    logic             rsel_q [0:N];
    logic             rsel_d [0:N];
    logic             qneg_q [0:N];
    logic             qneg_d [0:N];
    logic             rneg_q [0:N];
    logic             rneg_d [0:N];
    logic [TAG_W-1:0] tag_q  [0:N];
    logic [TAG_W-1:0] tag_d  [0:N];

    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] otag_q, otag_d;

    logic             stall;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  r_t, d_t;
    logic [XLEN:0]    sh_t, diff_t;
    logic [XLEN-1:0]  q_fix, r_fix;

    assign stall      = vld_q[S-1] & ~out_ready;
    assign in_ready   = ~stall & ~flush;
    assign out_valid  = vld_q[S-1];
    assign out_result = res_q;
    assign out_tag    = otag_q;
    assign busy       = |vld_q;

    always_comb begin
        if (flush) begin
            vld_d = '0;
        end else if (stall) begin
            vld_d = vld_q;
        end else begin
            vld_d = {vld_q[S-2:0], in_valid};
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dvs_d[i] = '0;
        end

        a_neg     = ~in_op[0] & in_dividend[XLEN-1];
        b_neg     = ~in_op[0] & in_divisor[XLEN-1];
        rem_d[0]  = '0;
        dq_d[0]   = a_neg ? -in_dividend : in_dividend;
        dvs_d[0]  = b_neg ? -in_divisor : in_divisor;
        // A zero divisor must yield an all-ones quotient for signed ops too, so never negate it.
        qneg_d[0] = (a_neg ^ b_neg) & (|in_divisor);
        rneg_d[0] = a_neg;
        rsel_d[0] = in_op[1];
        tag_d[0]  = in_tag;

        r_t    = '0;
        d_t    = '0;
        sh_t   = '0;
        diff_t = '0;
        for (int i = 1; i <= N; i++) begin
            r_t = rem_q[i-1];
            d_t = dq_q[i-1];
            for (int b = 0; b < BPS; b++) begin
                sh_t   = {r_t, d_t[XLEN-1]};
                diff_t = sh_t - {1'b0, dvs_q[i-1]};
                d_t    = {d_t[XLEN-2:0], ~diff_t[XLEN]};
                r_t    = diff_t[XLEN] ? sh_t[XLEN-1:0] : diff_t[XLEN-1:0];
            end
            rem_d[i]  = r_t;
            dq_d[i]   = d_t;
            qneg_d[i] = qneg_q[i-1];
            rneg_d[i] = rneg_q[i-1];
            rsel_d[i] = rsel_q[i-1];
            tag_d[i]  = tag_q[i-1];
            if (i < N) begin
                dvs_d[i] = dvs_q[i-1];
            end
        end

        q_fix  = qneg_q[N] ? -dq_q[N] : dq_q[N];
        r_fix  = rneg_q[N] ? -rem_q[N] : rem_q[N];
        res_d  = rsel_q[N] ? r_fix : q_fix;
        otag_d = tag_q[N];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by vld_q.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = 0; i <= N; i++) begin
                rem_q[i]  <= rem_d[i];
                dq_q[i]   <= dq_d[i];
                qneg_q[i] <= qneg_d[i];
                rneg_q[i] <= rneg_d[i];
                rsel_q[i] <= rsel_d[i];
                tag_q[i]  <= tag_d[i];
            end
            for (int i = 0; i < N; i++) begin
                dvs_q[i] <= dvs_d[i];
            end
            res_q  <= res_d;
            otag_q <= otag_d;
        end
    end

endmodule
